ckt_test_driver: RTL

- Test-side counterpart of the benchmark-circuit wrapper: generates the 33-bit input patterns that drive the wrapper's in_val and captures the 25-bit out_val responses.
- Patterns come from an LFSR. Responses are compacted into a MISR signature and compared against a golden signature, giving a pass/fail result for Trojan detection.
- Sits between the host/control logic and the combinational wrapper under test, in the same clk domain.

---
 rtl/ckt_test_pkg.sv | 30 +++
 rtl/misr_compactor.sv | 43 ++++
 rtl/ckt_test_driver.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ckt_test_pkg.sv
// Shared types and constants for the benchmark-circuit test driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, LFSR/MISR tap positions and default widths.
// The tap positions are tied to the default widths (x^33+x^20+1 for the
// pattern LFSR, x^25+x^22+1 for the response MISR).
package ckt_test_pkg;

    // Default pattern / response widths of the wrapped benchmark circuit.
    localparam int IN_W_DEF  = 33;
    localparam int OUT_W_DEF = 25;

    // Pattern LFSR feedback taps: x^33 + x^20 + 1.
    localparam int LFSR_TAP_A = 32;
    localparam int LFSR_TAP_B = 19;

    // Response MISR feedback taps: x^25 + x^22 + 1.
    localparam int MISR_TAP_A = 24;
    localparam int MISR_TAP_B = 21;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_APPLY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/misr_compactor.sv
// Multiple-input signature register compacting one response word per capture.
// Latency: signature updates on the edge where capture_en is high; sig_next is combinational.
// Backpressure: none; the caller qualifies clear/capture_en (clear wins over capture).
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset (signature -> 0)
//   clear        load zero into the signature
//   capture_en   fold data into the signature
//   data         response word to compact
//   signature    current signature
//   sig_next     value the signature takes on a capture (used for early compare)
module misr_compactor
    import ckt_test_pkg::*;
#(
    parameter int WIDTH = OUT_W_DEF,
    parameter int TAP_A = MISR_TAP_A,
    parameter int TAP_B = MISR_TAP_B
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             capture_en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] signature,
    output logic [WIDTH-1:0] sig_next
);

    // Shift left, feed back the tap XOR into bit 0, then fold in the response.
    always_comb begin
        sig_next = {signature[WIDTH-2:0], signature[TAP_A] ^ signature[TAP_B]} ^ data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            signature <= '0;
        end else if (clear) begin
            signature <= '0;
        end else if (capture_en) begin
            signature <= sig_next;
        end
    end

endmodule

// File: rtl/ckt_test_driver.sv
// LFSR pattern generator + MISR response compactor driving a combinational benchmark wrapper.
// Latency: done rises 1 + N*(SETTLE+1) cycles after the start-accept edge.
// Backpressure: enable low freezes all state; start is only honoured in IDLE/DONE with enable high.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   enable        global advance qualifier
//   start         one-cycle run request (IDLE/DONE only)
//   num_patterns  pattern count, latched on start accept
//   golden_sig    expected signature, latched on start accept
//   dut_in        pattern driven to the wrapper's in_val
//   dut_out       response from the wrapper's out_val
//   busy          high in LOAD/APPLY/CAPTURE
//   done          high in DONE
//   pass          signature matched golden (valid while done)
//   signature     current MISR value
//   pattern_idx   patterns captured so far
module ckt_test_driver
    import ckt_test_pkg::*;
#(
    parameter int              IN_W      = IN_W_DEF,
    parameter int              OUT_W     = OUT_W_DEF,
    parameter int              CNT_W     = 16,
    parameter int              SETTLE    = 2,
    parameter logic [IN_W-1:0] LFSR_SEED = IN_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [OUT_W-1:0] golden_sig,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] pattern_idx
);

    // SETTLE is limited to 1..15, so a 4-bit settle counter always suffices.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_lat;
    logic [OUT_W-1:0] gold_lat;
    logic [3:0]       settle_cnt;
    logic [IN_W-1:0]  lfsr_nxt;
    logic [OUT_W-1:0] sig_next;
    logic             last_pattern;
    logic             settle_end;
    logic             misr_clear;
    logic             misr_capture;

    assign lfsr_nxt     = {dut_in[IN_W-2:0], dut_in[LFSR_TAP_A] ^ dut_in[LFSR_TAP_B]};
    // pattern_idx still holds the pre-capture count during CAPTURE.
    assign last_pattern = (pattern_idx + CNT_W'(1)) == cnt_lat;
    assign settle_end   = settle_cnt == SETTLE_LAST;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (enable) begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = (cnt_lat == '0) ? ST_DONE : ST_APPLY;
            end
            ST_APPLY: begin
                if (settle_end) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_nxt = last_pattern ? ST_DONE : ST_APPLY;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- state outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_LOAD, ST_APPLY, ST_CAPTURE: busy = 1'b1;
            ST_DONE:                       done = 1'b1;
            default:                       ;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    // pass is resolved on the edge that enters DONE, so it is already valid
    // in the first cycle done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in      <= '0;
            pattern_idx <= '0;
            settle_cnt  <= '0;
            cnt_lat     <= '0;
            gold_lat    <= '0;
            pass        <= 1'b0;
        end else if (enable) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cnt_lat  <= num_patterns;
                        gold_lat <= golden_sig;
                        pass     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    dut_in      <= LFSR_SEED;
                    pattern_idx <= '0;
                    settle_cnt  <= '0;
                    if (cnt_lat == '0) begin
                        // Empty run: the cleared signature is compared directly.
                        pass <= (gold_lat == '0);
                    end
                end
                ST_APPLY: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                ST_CAPTURE: begin
                    dut_in      <= lfsr_nxt;
                    pattern_idx <= pattern_idx + CNT_W'(1);
                    settle_cnt  <= '0;
                    if (last_pattern) begin
                        pass <= (sig_next == gold_lat);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- response compaction
    assign misr_clear   = enable && (state == ST_LOAD);
    assign misr_capture = enable && (state == ST_CAPTURE);

    misr_compactor #(
        .WIDTH (OUT_W),
        .TAP_A (MISR_TAP_A),
        .TAP_B (MISR_TAP_B)
    ) u_misr (
        .clk        (clk),
        .rst        (rst),
        .clear      (misr_clear),
        .capture_en (misr_capture),
        .data       (dut_out),
        .signature  (signature),
        .sig_next   (sig_next)
    );

endmodule
